// File: rtl/axi_lite_bram_bank.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_bram_bank
//  Purpose  : AXI4-Lite slave giving the PS word access to NUM_BANKS BRAM
//             banks shared with one PL port. Bank ownership is handed over
//             with a CTRL register handshake (start / done).
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_bram_bank #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int NUM_BANKS       = 4,
    localparam int BANK_BITS      = $clog2(NUM_BANKS),
    localparam int BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    // AXI4-Lite write address
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    // AXI4-Lite write data
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    // AXI4-Lite write response
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    // AXI4-Lite read address
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    // AXI4-Lite read data
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    // PL access port
    input  logic                        pl_en,
    input  logic                        pl_we,
    input  logic [BANK_W-1:0]           pl_bank,
    input  logic [BRAM_ADDR_WIDTH-1:0]  pl_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  pl_wdata,
    output logic [BRAM_DATA_WIDTH-1:0]  pl_rdata,
    // Ownership handshake
    output logic                        pl_start,
    output logic                        pl_owner,
    input  logic                        pl_done
);

    localparam int DEPTH  = 1 << BRAM_ADDR_WIDTH;
    localparam int NBYTES = BRAM_DATA_WIDTH / 8;
    localparam int OFF_W  = AXI_ADDR_WIDTH - 3;

    localparam logic [1:0]       c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]       c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]       c_RESP_DECERR = 2'b11;
    localparam logic [OFF_W-1:0] c_OFF_CTRL    = OFF_W'(0);
    localparam logic [OFF_W-1:0] c_OFF_INFO    = OFF_W'(1);
    localparam logic [AXI_DATA_WIDTH-1:0] c_INFO =
        AXI_DATA_WIDTH'({8'd0, 8'(NUM_BANKS), 8'(BRAM_ADDR_WIDTH), 8'(BRAM_DATA_WIDTH)});

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_RESP = 2'd1,
        S_RD_WAIT = 2'd2,
        S_RD_RESP = 2'd3
    } state_t;

    state_t                      r_state;

    // Write channel holding registers
    logic                        r_aw_held;
    logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic                        r_w_held;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;

    // Response registers
    logic                        r_bvalid;
    logic [1:0]                  r_bresp;
    logic                        r_rvalid;
    logic [1:0]                  r_rresp;
    logic [AXI_DATA_WIDTH-1:0]   r_rdata;

    // Read context carried from the AR handshake into RD_WAIT
    logic                        r_rd_is_data;
    logic [BANK_W-1:0]           r_rd_bank;
    logic [1:0]                  r_rd_resp;
    logic [AXI_DATA_WIDTH-1:0]   r_rd_regval;

    // Ownership state
    logic                        r_owner;
    logic                        r_done;
    logic                        r_pl_start;
    logic [BANK_W-1:0]           r_pl_bank_q;

    // Address decode
    logic                        w_aw_is_ctrl;
    logic [OFF_W-1:0]            w_aw_off;
    logic [BRAM_ADDR_WIDTH-1:0]  w_aw_word;
    logic [BANK_W-1:0]           w_aw_bank;
    logic                        w_ar_is_ctrl;
    logic [OFF_W-1:0]            w_ar_off;
    logic [BRAM_ADDR_WIDTH-1:0]  w_ar_word;
    logic [BANK_W-1:0]           w_ar_bank;

    logic                        w_both_held;
    logic                        w_wr_go;
    logic                        w_rd_go;
    logic                        w_pl_done_eff;
    logic [1:0]                  w_wr_resp;
    logic [1:0]                  w_rd_resp;
    logic [AXI_DATA_WIDTH-1:0]   w_rd_regval;

    // Shared bank port (only one master drives it in any cycle)
    logic [NUM_BANKS-1:0]        w_mem_en;
    logic                        w_mem_we;
    logic [NBYTES-1:0]           w_mem_be;
    logic [BRAM_ADDR_WIDTH-1:0]  w_mem_addr;
    logic [BRAM_DATA_WIDTH-1:0]  w_mem_wdata;
    logic [BRAM_DATA_WIDTH-1:0]  w_bank_rdata [NUM_BANKS];

    assign w_aw_is_ctrl = r_awaddr[AXI_ADDR_WIDTH-1];
    assign w_aw_off     = r_awaddr[AXI_ADDR_WIDTH-2:2];
    assign w_aw_word    = r_awaddr[2 +: BRAM_ADDR_WIDTH];
    assign w_ar_is_ctrl = s_axi_araddr[AXI_ADDR_WIDTH-1];
    assign w_ar_off     = s_axi_araddr[AXI_ADDR_WIDTH-2:2];
    assign w_ar_word    = s_axi_araddr[2 +: BRAM_ADDR_WIDTH];

    // Bank index sits just above the word address; absent for a single bank
    generate
        if (BANK_BITS > 0) begin : g_bank_sel
            assign w_aw_bank = r_awaddr[2+BRAM_ADDR_WIDTH +: BANK_BITS];
            assign w_ar_bank = s_axi_araddr[2+BRAM_ADDR_WIDTH +: BANK_BITS];
        end else begin : g_bank_sel_single
            assign w_aw_bank = '0;
            assign w_ar_bank = '0;
        end
    endgenerate

    // A complete write always beats a concurrent read request
    assign w_both_held   = r_aw_held && r_w_held;
    assign w_wr_go       = !reset && (r_state == S_IDLE) && w_both_held;
    assign w_rd_go       = !reset && (r_state == S_IDLE) && s_axi_arvalid && !w_both_held;
    assign w_pl_done_eff = pl_done && r_owner;

    assign s_axi_awready = !reset && (r_state == S_IDLE) && !r_aw_held;
    assign s_axi_wready  = !reset && (r_state == S_IDLE) && !r_w_held;
    assign s_axi_arready = w_rd_go;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign pl_start      = r_pl_start;
    assign pl_owner      = r_owner;
    assign pl_rdata      = (r_owner && !reset) ? w_bank_rdata[r_pl_bank_q] : '0;

    // Write response: data space is refused while the PL owns the banks
    always_comb begin
        w_wr_resp = c_RESP_OKAY;
        if (!w_aw_is_ctrl) begin
            if (r_owner) w_wr_resp = c_RESP_SLVERR;
        end else if ((w_aw_off != c_OFF_CTRL) && (w_aw_off != c_OFF_INFO)) begin
            w_wr_resp = c_RESP_DECERR;
        end
    end

    // Read response and register value for control-space reads
    always_comb begin
        w_rd_resp   = c_RESP_OKAY;
        w_rd_regval = '0;
        if (!w_ar_is_ctrl) begin
            if (r_owner) w_rd_resp = c_RESP_SLVERR;
        end else if (w_ar_off == c_OFF_CTRL) begin
            w_rd_regval = {{(AXI_DATA_WIDTH-2){1'b0}}, r_done, r_owner};
        end else if (w_ar_off == c_OFF_INFO) begin
            w_rd_regval = c_INFO;
        end else begin
            w_rd_resp = c_RESP_DECERR;
        end
    end

    // Bank port mux: PL when it owns the banks, otherwise the AXI FSM
    always_comb begin
        w_mem_en    = '0;
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (!reset) begin
            if (r_owner) begin
                w_mem_we    = pl_we;
                w_mem_be    = '1;
                w_mem_addr  = pl_addr;
                w_mem_wdata = pl_wdata;
                if (pl_en) w_mem_en[pl_bank] = 1'b1;
            end else if (w_wr_go) begin
                w_mem_we    = 1'b1;
                w_mem_be    = r_wstrb[NBYTES-1:0];
                w_mem_addr  = w_aw_word;
                w_mem_wdata = r_wdata[BRAM_DATA_WIDTH-1:0];
                if (!w_aw_is_ctrl) w_mem_en[w_aw_bank] = 1'b1;
            end else if (w_rd_go) begin
                w_mem_addr = w_ar_word;
                if (!w_ar_is_ctrl) w_mem_en[w_ar_bank] = 1'b1;
            end
        end
    end

    generate
        for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            logic [BRAM_DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
            logic [BRAM_DATA_WIDTH-1:0] r_q;

            // Read-first synchronous port with byte enables; contents survive reset
            always_ff @(posedge clock) begin
                if (w_mem_en[gb]) begin
                    if (w_mem_we) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (w_mem_be[i]) r_mem[w_mem_addr][i*8 +: 8] <= w_mem_wdata[i*8 +: 8];
                        end
                    end
                    r_q <= r_mem[w_mem_addr];
                end
            end

            assign w_bank_rdata[gb] = r_q;
        end
    endgenerate

    // AXI FSM, channel holding registers and ownership handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_aw_held    <= 1'b0;
            r_awaddr     <= '0;
            r_w_held     <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bvalid     <= 1'b0;
            r_bresp      <= c_RESP_OKAY;
            r_rvalid     <= 1'b0;
            r_rresp      <= c_RESP_OKAY;
            r_rdata      <= '0;
            r_rd_is_data <= 1'b0;
            r_rd_bank    <= '0;
            r_rd_resp    <= c_RESP_OKAY;
            r_rd_regval  <= '0;
            r_owner      <= 1'b0;
            r_done       <= 1'b0;
            r_pl_start   <= 1'b0;
            r_pl_bank_q  <= '0;
        end else begin
            r_pl_start <= 1'b0;

            if (s_axi_awready && s_axi_awvalid) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi_awaddr;
            end
            if (s_axi_wready && s_axi_wvalid) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end

            if (r_owner && pl_en) r_pl_bank_q <= pl_bank;

            // PL completion returns the banks; it overrides any PS CTRL write
            if (w_pl_done_eff) begin
                r_owner <= 1'b0;
                r_done  <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_wr_go) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bresp   <= w_wr_resp;
                        r_bvalid  <= 1'b1;
                        r_state   <= S_WR_RESP;
                        if (w_aw_is_ctrl && (w_aw_off == c_OFF_CTRL) && !w_pl_done_eff) begin
                            if (r_wdata[0] && !r_owner) begin
                                r_owner    <= 1'b1;
                                r_pl_start <= 1'b1;
                            end
                            if (r_wdata[1]) r_done <= 1'b0;
                        end
                    end else if (w_rd_go) begin
                        r_rd_is_data <= !w_ar_is_ctrl;
                        r_rd_bank    <= w_ar_bank;
                        r_rd_resp    <= w_rd_resp;
                        r_rd_regval  <= w_rd_regval;
                        r_state      <= S_RD_WAIT;
                    end
                end
                S_WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    if (r_rd_is_data && (r_rd_resp == c_RESP_OKAY)) begin
                        r_rdata <= AXI_DATA_WIDTH'(w_bank_rdata[r_rd_bank]);
                    end else begin
                        r_rdata <= r_rd_regval;
                    end
                    r_rresp  <= r_rd_resp;
                    r_rvalid <= 1'b1;
                    r_state  <= S_RD_RESP;
                end
                S_RD_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Byte-offset bits and data/strobe lanes above the bank width carry no meaning
    logic w_unused;
    assign w_unused = ^{r_awaddr[1:0], s_axi_araddr[1:0], r_wdata, r_wstrb};

endmodule
`default_nettype wire
